wave_dds_ctrl: RTL

- Phase-accumulator sequencer for the DAC waveform ROMs (sine, square, triangle; 12-bit address, 8-bit data, registered output).
- Generates the shared ROM address, selects and aligns the ROM output, applies amplitude scaling, and presents one offset-binary sample per clock to the DAC driver.
- Frequency, waveform and amplitude changes take effect only at period wrap, so the output never glitches mid-period.

---
 rtl/wave_dds_ctrl_if.sv | 37 +++
 rtl/wave_dds_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wave_dds_ctrl_if.sv
// Control, ROM and DAC bundle for the DDS waveform sequencer.
// master = host/ROM/DAC side, slave = wave_dds_ctrl.
interface wave_dds_ctrl_if #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              enable;
  logic [ACC_W-1:0]  freq_word;
  logic              freq_load;
  logic [1:0]        wave_sel;
  logic [2:0]        amp_shift;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] sine_data;
  logic [DATA_W-1:0] square_data;
  logic [DATA_W-1:0] tri_data;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
  logic              period_start;
  logic              busy;

  modport master (
    output enable, freq_word, freq_load,
    output wave_sel, amp_shift,
    output sine_data, square_data, tri_data,
    input  rom_addr, dac_data, dac_valid,
    input  period_start, busy
  );

  modport slave (
    input  enable, freq_word, freq_load,
    input  wave_sel, amp_shift,
    input  sine_data, square_data, tri_data,
    output rom_addr, dac_data, dac_valid,
    output period_start, busy
  );
endinterface

// File: rtl/wave_dds_ctrl.sv
// Phase-accumulator DDS sequencer: ROM addressing, waveform select,
// amplitude scaling; parameter changes land only on period wrap.
module wave_dds_ctrl #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  wave_dds_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;
  localparam int L = ROM_LAT;
  localparam logic [DATA_W-1:0] MID =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  freq_act_q, freq_act_d;
  logic [ACC_W-1:0]  freq_pend_q, freq_pend_d;
  logic [1:0]        wave_act_q, wave_act_d;
  logic [2:0]        shift_act_q, shift_act_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  // Index 0 is the address stage; index L meets the ROM douta.
  logic [L:0]             p_live_q, p_live_d;
  logic [L:0]             p_first_q, p_first_d;
  logic [L:0][1:0]        p_wave_q, p_wave_d;
  logic [L:0][2:0]        p_shift_q, p_shift_d;
  logic [L:0][DATA_W-1:0] p_saw_q, p_saw_d;

  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              dac_valid_q, dac_valid_d;
  logic              period_start_q, period_start_d;

  logic [ACC_W:0]         sum;
  logic                   wrap;
  logic                   issue;
  logic [DATA_W-1:0]      raw;
  logic signed [DATA_W:0] s;
  logic signed [DATA_W:0] sh;

  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, freq_act_q};
    wrap = sum[ACC_W];
    state_d = state_q;
    acc_d = acc_q;
    freq_act_d = freq_act_q;
    wave_act_d = wave_act_q;
    shift_act_d = shift_act_q;
    first_d = first_q;
    issue = 1'b0;
    freq_pend_d = bus.freq_load ? bus.freq_word
                                : freq_pend_q;
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        if (bus.enable) begin
          freq_act_d = freq_pend_d;
          wave_act_d = bus.wave_sel;
          shift_act_d = bus.amp_shift;
          first_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        acc_d = sum[ACC_W-1:0];
        first_d = 1'b0;
        if (wrap) begin
          freq_act_d = freq_pend_d;
          wave_act_d = bus.wave_sel;
          shift_act_d = bus.amp_shift;
          first_d = 1'b1;
        end
        if (!bus.enable) state_d = S_STOP;
      end
      S_STOP: begin
        issue = 1'b1;
        acc_d = sum[ACC_W-1:0];
        first_d = 1'b0;
        if (bus.enable) state_d = S_RUN;
        if (wrap && bus.enable) begin
          freq_act_d = freq_pend_d;
          wave_act_d = bus.wave_sel;
          shift_act_d = bus.amp_shift;
          first_d = 1'b1;
        end else if (wrap) begin
          acc_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_addr_d = acc_q[ACC_W-1 -: ADDR_W];
    p_live_d  = {p_live_q[L-1:0], issue};
    p_first_d = {p_first_q[L-1:0], issue & first_q};
    p_wave_d  = {p_wave_q[L-1:0], wave_act_q};
    p_shift_d = {p_shift_q[L-1:0], shift_act_q};
    p_saw_d   = {p_saw_q[L-1:0],
                 acc_q[ACC_W-1 -: DATA_W]};
  end

  always_comb begin
    unique case (p_wave_q[L])
      2'd0: raw = bus.sine_data;
      2'd1: raw = bus.square_data;
      2'd2: raw = bus.tri_data;
      2'd3: raw = p_saw_q[L];
    endcase
    s = $signed({1'b0, raw}) - $signed({1'b0, MID});
    sh = s >>> p_shift_q[L];
    dac_valid_d = p_live_q[L];
    period_start_d = p_live_q[L] & p_first_q[L];
    dac_data_d = p_live_q[L] ? MID + sh[DATA_W-1:0]
                             : MID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q <= '0;
      freq_act_q <= '0;
      freq_pend_q <= '0;
      wave_act_q <= '0;
      shift_act_q <= '0;
      first_q <= 1'b0;
      rom_addr_q <= '0;
      p_live_q <= '0;
      p_first_q <= '0;
      p_wave_q <= '0;
      p_shift_q <= '0;
      p_saw_q <= '0;
      dac_data_q <= MID;
      dac_valid_q <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      freq_act_q <= freq_act_d;
      freq_pend_q <= freq_pend_d;
      wave_act_q <= wave_act_d;
      shift_act_q <= shift_act_d;
      first_q <= first_d;
      rom_addr_q <= rom_addr_d;
      p_live_q <= p_live_d;
      p_first_q <= p_first_d;
      p_wave_q <= p_wave_d;
      p_shift_q <= p_shift_d;
      p_saw_q <= p_saw_d;
      dac_data_q <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      period_start_q <= period_start_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.dac_data = dac_data_q;
  assign bus.dac_valid = dac_valid_q;
  assign bus.period_start = period_start_q;
  assign bus.busy = (state_q != S_IDLE) | (|p_live_q)
                  | dac_valid_q;

endmodule
